// File: rtl/dtree_pkg.sv
// Shared types for the sequential decision-tree walker: node word layout,
// walker states, widths, and the trained tree contents.
package dtree_pkg;

    localparam int FEAT_W     = 8;
    localparam int CLASS_W    = 5;
    localparam int NODE_IDX_W = 4;
    localparam int FIDX_W     = 3;
    localparam int NB_W       = 3;

    typedef enum logic [1:0] {
        LOAD,
        WALK,
        DONE
    } state_t;

    typedef struct packed {
        logic                  leaf;
        logic [FIDX_W-1:0]     fidx;
        logic [NB_W-1:0]       nb;
        logic [FEAT_W-1:0]     thr;
        logic [NODE_IDX_W-1:0] lo;
        logic [NODE_IDX_W-1:0] hi;
        logic [CLASS_W-1:0]    cls;
    } node_t;

    function automatic node_t leaf_node(input logic [CLASS_W-1:0] cls);
        node_t n;
        n      = '0;
        n.leaf = 1'b1;
        n.cls  = cls;
        return n;
    endfunction

    function automatic node_t branch_node(
        input logic [FIDX_W-1:0]     fidx,
        input logic [NB_W-1:0]       nb,
        input logic [FEAT_W-1:0]     thr,
        input logic [NODE_IDX_W-1:0] lo,
        input logic [NODE_IDX_W-1:0] hi
    );
        node_t n;
        n      = '0;
        n.fidx = fidx;
        n.nb   = nb;
        n.thr  = thr;
        n.lo   = lo;
        n.hi   = hi;
        return n;
    endfunction

    // Trained tree; regenerate this table when the classifier is retrained.
    function automatic node_t node_init(input int idx);
        case (idx)
            0:       return branch_node(3'd6, 3'd3, 8'd0, 4'd1, 4'd2);
            1:       return leaf_node(5'd5);
            2:       return branch_node(3'd1, 3'd2, 8'd1, 4'd3, 4'd4);
            3:       return leaf_node(5'd19);
            4:       return leaf_node(5'd10);
            default: return leaf_node(5'd0);
        endcase
    endfunction

    // Top nb bits of the feature, right-aligned; nb of 0 selects all 8 bits.
    function automatic logic [FEAT_W-1:0] feat_slice(
        input logic [FEAT_W-1:0] value,
        input logic [NB_W-1:0]   nb
    );
        logic [3:0] shamt;
        shamt = (nb == '0) ? 4'd0 : (4'd8 - {1'b0, nb});
        return value >> shamt;
    endfunction

endpackage

// File: rtl/dtree_node_rom.sv
// Combinational node table: node index in, node word out, filled from the
// trained tree description in dtree_pkg.
import dtree_pkg::*;

module dtree_node_rom #(
    parameter int NUM_NODES = 16
) (
    input  logic [$clog2(NUM_NODES)-1:0] node_idx,
    output node_t                        node_word
);

    node_t rom_table [NUM_NODES];

    generate
        for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_rom
            assign rom_table[gi] = node_init(gi);
        end
    endgenerate

    assign node_word = rom_table[node_idx];

endmodule

// File: rtl/dtree_seq_walker.sv
// Sequential decision-tree classifier: loads a feature frame, walks the node
// table one node per cycle with a single comparator, then offers the class.
// Optional macro DTREE_WATCHDOG_EN adds the err port and a step-limit abort.
import dtree_pkg::*;

module dtree_seq_walker #(
    parameter int NUM_FEAT  = 7,
    parameter int NUM_NODES = 16
`ifdef DTREE_WATCHDOG_EN
    ,
    parameter int MAX_DEPTH = 15,
    parameter int ERR_CLASS = 31
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               feat_valid,
    input  logic               feat_first,
    input  logic [FEAT_W-1:0]  feat_data,
    output logic               feat_ready,
    output logic               class_valid,
    output logic [CLASS_W-1:0] class_out,
    input  logic               class_ready
`ifdef DTREE_WATCHDOG_EN
    ,
    output logic               err
`endif
);

    localparam int CNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int IDX_W = $clog2(NUM_NODES);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   feat_cnt_reg, feat_cnt_next;
    logic [IDX_W-1:0]   node_reg, node_next;
    logic [CLASS_W-1:0] class_reg, class_next;

`ifdef DTREE_WATCHDOG_EN
    localparam int STEP_W = $clog2(MAX_DEPTH + 1);
    logic [STEP_W-1:0]  step_reg, step_next;
    logic               err_reg, err_next;
`endif

    node_t              node_word;
    logic [FEAT_W-1:0]  feat_mem [0:(1<<FIDX_W)-1];
    logic               feat_we;
    logic [FIDX_W-1:0]  feat_waddr;
    logic [FEAT_W-1:0]  slice;
    logic [IDX_W-1:0]   branch_idx;

    dtree_node_rom #(
        .NUM_NODES (NUM_NODES)
    ) u_node_rom (
        .node_idx  (node_reg),
        .node_word (node_word)
    );

    // Feature file holds the frame only; its contents are don't-care at reset.
    always_ff @(posedge clk) begin
        if (feat_we) begin
            feat_mem[feat_waddr] <= feat_data;
        end
    end

    assign slice      = feat_slice(feat_mem[node_word.fidx], node_word.nb);
    assign branch_idx = (slice <= node_word.thr) ? node_word.lo[IDX_W-1:0]
                                                 : node_word.hi[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= LOAD;
            feat_cnt_reg <= '0;
            node_reg     <= '0;
            class_reg    <= '0;
`ifdef DTREE_WATCHDOG_EN
            step_reg     <= '0;
            err_reg      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            feat_cnt_reg <= feat_cnt_next;
            node_reg     <= node_next;
            class_reg    <= class_next;
`ifdef DTREE_WATCHDOG_EN
            step_reg     <= step_next;
            err_reg      <= err_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        feat_cnt_next = feat_cnt_reg;
        node_next     = node_reg;
        class_next    = class_reg;
        feat_ready    = 1'b0;
        class_valid   = 1'b0;
        feat_we       = 1'b0;
        feat_waddr    = FIDX_W'(feat_cnt_reg);
`ifdef DTREE_WATCHDOG_EN
        step_next     = step_reg;
        err_next      = err_reg;
`endif
        case (state_reg)
            LOAD: begin
                feat_ready = 1'b1;
                if (feat_valid) begin
                    feat_we = 1'b1;
                    if (feat_first) begin
                        // Resync: a marked word always restarts the frame.
                        feat_waddr    = '0;
                        feat_cnt_next = CNT_W'(1);
                    end else if (feat_cnt_reg == CNT_W'(NUM_FEAT - 1)) begin
                        state_next    = WALK;
                        feat_cnt_next = '0;
                        node_next     = '0;
`ifdef DTREE_WATCHDOG_EN
                        step_next     = '0;
`endif
                    end else begin
                        feat_cnt_next = feat_cnt_reg + CNT_W'(1);
                    end
                end
            end
            WALK: begin
                if (node_word.leaf) begin
                    class_next = node_word.cls;
                    state_next = DONE;
`ifdef DTREE_WATCHDOG_EN
                end else if (step_reg == STEP_W'(MAX_DEPTH)) begin
                    class_next = CLASS_W'(ERR_CLASS);
                    err_next   = 1'b1;
                    state_next = DONE;
`endif
                end else begin
                    node_next = branch_idx;
`ifdef DTREE_WATCHDOG_EN
                    step_next = step_reg + STEP_W'(1);
`endif
                end
            end
            DONE: begin
                class_valid = 1'b1;
                if (class_ready) begin
                    state_next    = LOAD;
                    feat_cnt_next = '0;
`ifdef DTREE_WATCHDOG_EN
                    err_next      = 1'b0;
`endif
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    assign class_out = class_reg;
`ifdef DTREE_WATCHDOG_EN
    assign err = err_reg;
`endif

endmodule
